// File: rtl/axi_trace_replayer.sv
// rtl/axi_trace_replayer.sv - replays AXI descriptors onto an AXI bus; optional AXI_REPLAY_RESP_CHECK_EN response checking
package axi_trace_replayer_pkg;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned USER_W = 1;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [5:0]        atop;
        logic [USER_W-1:0] user;
    } axi_aw_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [USER_W-1:0] user;
    } axi_ar_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
        logic                last;
        logic [USER_W-1:0]   user;
    } axi_w_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [1:0]        resp;
        logic [USER_W-1:0] user;
    } axi_b_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic [USER_W-1:0] user;
    } axi_r_t;

    typedef struct packed {
        axi_aw_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } axi_resp_t;
endpackage

module axi_trace_replayer #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned IdWidth        = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned DelayWidth     = 16,
    parameter type axi_req_t  = axi_trace_replayer_pkg::axi_req_t,
    parameter type axi_resp_t = axi_trace_replayer_pkg::axi_resp_t
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [IdWidth-1:0]    cmd_id_i,
    input  logic [AddrWidth-1:0]  cmd_addr_i,
    input  logic [7:0]            cmd_len_i,
    input  logic [2:0]            cmd_size_i,
    input  logic [1:0]            cmd_burst_i,
    input  logic [DataWidth-1:0]  cmd_data_i,
    input  logic [DelayWidth-1:0] cmd_delay_i,
    output axi_req_t              axi_req_o,
    input  axi_resp_t             axi_resp_i,
    output logic                  busy_o,
    output logic [31:0]           wr_done_o,
    output logic [31:0]           rd_done_o,
    output logic                  err_o
);
    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

    typedef enum logic [1:0] {IDLE, WAIT, ISSUE_A, W_BEATS} state_t;

    state_t                state_q, state_d;
    logic                  live_q;
    logic                  write_q;
    logic [IdWidth-1:0]    id_q;
    logic [AddrWidth-1:0]  addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [DataWidth-1:0]  data_q;
    logic [DelayWidth-1:0] delay_q;
    logic [7:0]            beat_q;
    logic [OutW-1:0]       wr_out_q, rd_out_q;
    logic [31:0]           wr_done_q, rd_done_q;

    logic aw_valid, ar_valid, w_valid;
    logic cmd_hs, aw_hs, ar_hs, w_hs, b_hs, r_hs, r_last_hs;
    logic wr_room, rd_room;
    logic unused_resp;

    assign wr_room   = wr_out_q < OutW'(MaxOutstanding);
    assign rd_room   = rd_out_q < OutW'(MaxOutstanding);
    assign cmd_hs    = cmd_valid_i & cmd_ready_o;
    assign aw_hs     = aw_valid & axi_resp_i.aw_ready;
    assign ar_hs     = ar_valid & axi_resp_i.ar_ready;
    assign w_hs      = w_valid & axi_resp_i.w_ready;
    // b_ready/r_ready are simply live_q, so a response handshake needs only valid
    assign b_hs      = axi_resp_i.b_valid & live_q;
    assign r_hs      = axi_resp_i.r_valid & live_q;
    assign r_last_hs = r_hs & axi_resp_i.r.last;
    assign unused_resp = ^axi_resp_i;

    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        aw_valid    = 1'b0;
        ar_valid    = 1'b0;
        w_valid     = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = live_q;
                if (cmd_valid_i && live_q) begin
                    state_d = (cmd_delay_i != '0) ? WAIT : ISSUE_A;
                end
            end
            WAIT: begin
                if (delay_q <= DelayWidth'(1)) state_d = ISSUE_A;
            end
            ISSUE_A: begin
                // Counters only fall while parked here, so room never disappears once valid is up
                if (write_q) begin
                    aw_valid = wr_room;
                    if (aw_valid && axi_resp_i.aw_ready) state_d = W_BEATS;
                end else begin
                    ar_valid = rd_room;
                    if (ar_valid && axi_resp_i.ar_ready) state_d = IDLE;
                end
            end
            W_BEATS: begin
                w_valid = 1'b1;
                if (axi_resp_i.w_ready && beat_q == len_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            live_q    <= 1'b0;
            write_q   <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            data_q    <= '0;
            delay_q   <= '0;
            beat_q    <= '0;
            wr_out_q  <= '0;
            rd_out_q  <= '0;
            wr_done_q <= '0;
            rd_done_q <= '0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            if (cmd_hs) begin
                write_q <= cmd_write_i;
                id_q    <= cmd_id_i;
                addr_q  <= cmd_addr_i;
                len_q   <= cmd_len_i;
                size_q  <= cmd_size_i;
                burst_q <= cmd_burst_i;
                data_q  <= cmd_data_i;
                delay_q <= cmd_delay_i;
            end else if (state_q == WAIT) begin
                delay_q <= delay_q - DelayWidth'(1);
            end
            if (aw_hs) begin
                beat_q <= '0;
            end else if (w_hs) begin
                beat_q <= beat_q + 8'd1;
            end
            if (aw_hs && !b_hs) begin
                wr_out_q <= wr_out_q + OutW'(1);
            end else if (b_hs && !aw_hs && wr_out_q != '0) begin
                wr_out_q <= wr_out_q - OutW'(1);
            end
            if (ar_hs && !r_last_hs) begin
                rd_out_q <= rd_out_q + OutW'(1);
            end else if (r_last_hs && !ar_hs && rd_out_q != '0) begin
                rd_out_q <= rd_out_q - OutW'(1);
            end
            if (b_hs)      wr_done_q <= wr_done_q + 32'd1;
            if (r_last_hs) rd_done_q <= rd_done_q + 32'd1;
        end
    end

    always_comb begin
        axi_req_o          = '0;
        axi_req_o.aw.id    = id_q;
        axi_req_o.aw.addr  = addr_q;
        axi_req_o.aw.len   = len_q;
        axi_req_o.aw.size  = size_q;
        axi_req_o.aw.burst = burst_q;
        axi_req_o.aw_valid = aw_valid;
        axi_req_o.w.data   = data_q + DataWidth'(beat_q);
        axi_req_o.w.strb   = '1;
        axi_req_o.w.last   = (beat_q == len_q);
        axi_req_o.w_valid  = w_valid;
        axi_req_o.b_ready  = live_q;
        axi_req_o.ar.id    = id_q;
        axi_req_o.ar.addr  = addr_q;
        axi_req_o.ar.len   = len_q;
        axi_req_o.ar.size  = size_q;
        axi_req_o.ar.burst = burst_q;
        axi_req_o.ar_valid = ar_valid;
        axi_req_o.r_ready  = live_q;
    end

    assign busy_o    = (state_q != IDLE) || (wr_out_q != '0) || (rd_out_q != '0);
    assign wr_done_o = wr_done_q;
    assign rd_done_o = rd_done_q;

`ifdef AXI_REPLAY_RESP_CHECK_EN
    logic err_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if ((b_hs && axi_resp_i.b.resp != 2'b00) || (r_hs && axi_resp_i.r.resp != 2'b00)) begin
            err_q <= 1'b1;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_axi_trace_replayer.sv
// tb/tb_axi_trace_replayer.sv - randomized bench for axi_trace_replayer with transaction-level reference model
module tb_axi_trace_replayer;
    import axi_trace_replayer_pkg::*;

    localparam int MAX_OUT = 2;
`ifdef AXI_REPLAY_RESP_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        bit        wr;
        bit [3:0]  id;
        bit [31:0] addr;
        bit [7:0]  len;
        bit [2:0]  size;
        bit [1:0]  burst;
        bit [63:0] data;
        int        delay;
    } desc_t;

    typedef struct {
        bit [3:0] id;
        bit [1:0] resp;
        bit       last;
    } rbeat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_id;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [63:0] cmd_data;
    logic [15:0] cmd_delay;
    axi_req_t    req;
    axi_resp_t   resp;
    logic        busy, err;
    logic [31:0] wr_done, rd_done;

    always #5 clk = ~clk;

    axi_trace_replayer #(.MaxOutstanding(MAX_OUT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_id_i(cmd_id), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_size_i(cmd_size),
        .cmd_burst_i(cmd_burst), .cmd_data_i(cmd_data), .cmd_delay_i(cmd_delay),
        .axi_req_o(req), .axi_resp_i(resp),
        .busy_o(busy), .wr_done_o(wr_done), .rd_done_o(rd_done), .err_o(err)
    );

    int n_cmp = 0, n_fail = 0, cyc = 0;
    bit rst_req = 1'b0;
    int p_aw = 100, p_w = 100, p_ar = 100, p_b = 100, p_r = 100;
    bit r_hold = 1'b0, rand_resp = 1'b0;
    logic [1:0] force_bresp = 2'b00;
    int gap = 0, gap_max = 0;
    bit clr_cmd = 0, clr_b = 0, clr_r = 0;
    desc_t  cmd_q[$];
    logic [1:0] b_q[$];
    rbeat_t r_q[$];

    bit alive = 0, act = 0, a_done = 0, m_err = 0;
    desc_t cur;
    int earliest = 0, beat = 0, wr_out = 0, rd_out = 0;
    bit [31:0] m_wr_done = 0, m_rd_done = 0;
    int hs_cyc = -1, first_a = -1, first_rlast = -1;
    logic [63:0] w_log[$];
    bit last_log[$];

    task automatic cmp(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: actual %0h required %0h", nm, cyc, a, e);
        end
    endtask

    task automatic drive();
        rst_n = rst_req;
        if (clr_cmd) cmd_valid = 1'b0;
        if (clr_b) resp.b_valid = 1'b0;
        if (clr_r) resp.r_valid = 1'b0;
        clr_cmd = 0; clr_b = 0; clr_r = 0;
        if (!rst_n) begin
            cmd_q.delete(); b_q.delete(); r_q.delete();
            cmd_valid = 1'b0; resp.b_valid = 1'b0; resp.r_valid = 1'b0;
        end
        if (!cmd_valid && cmd_q.size() > 0) begin
            if (gap > 0) gap--;
            else begin
                cmd_write = cmd_q[0].wr;   cmd_id   = cmd_q[0].id;
                cmd_addr  = cmd_q[0].addr; cmd_len  = cmd_q[0].len;
                cmd_size  = cmd_q[0].size; cmd_burst = cmd_q[0].burst;
                cmd_data  = cmd_q[0].data; cmd_delay = 16'(cmd_q[0].delay);
                cmd_valid = 1'b1;
            end
        end
        resp.aw_ready = ($urandom_range(99) < p_aw);
        resp.w_ready  = ($urandom_range(99) < p_w);
        resp.ar_ready = ($urandom_range(99) < p_ar);
        if (!resp.b_valid && b_q.size() > 0 && $urandom_range(99) < p_b) begin
            resp.b_valid = 1'b1;
            resp.b.resp  = b_q[0];
            resp.b.id    = 4'($urandom);
        end
        if (!resp.r_valid && r_q.size() > 0 && !r_hold && $urandom_range(99) < p_r) begin
            resp.r_valid = 1'b1;
            resp.r.id    = r_q[0].id;
            resp.r.resp  = r_q[0].resp;
            resp.r.last  = r_q[0].last;
            resp.r.data  = {$urandom, $urandom};
        end
    endtask

    task automatic check();
        bit e_rdy, e_aw, e_ar, e_w, e_busy;
        e_rdy  = rst_n && alive && !act;
        e_aw   = rst_n && alive && act && cur.wr && !a_done && cyc >= earliest && wr_out < MAX_OUT;
        e_ar   = rst_n && alive && act && !cur.wr && !a_done && cyc >= earliest && rd_out < MAX_OUT;
        e_w    = rst_n && alive && act && cur.wr && a_done;
        e_busy = rst_n && (act || wr_out > 0 || rd_out > 0);
        cmp("cmd_ready", cmd_ready, e_rdy);
        cmp("aw_valid", req.aw_valid, e_aw);
        cmp("ar_valid", req.ar_valid, e_ar);
        cmp("w_valid", req.w_valid, e_w);
        cmp("b_ready", req.b_ready, rst_n && alive);
        cmp("r_ready", req.r_ready, rst_n && alive);
        cmp("busy", busy, e_busy);
        cmp("wr_done", wr_done, rst_n ? m_wr_done : 32'd0);
        cmp("rd_done", rd_done, rst_n ? m_rd_done : 32'd0);
        cmp("err", err, rst_n ? m_err : 1'b0);
        if (e_aw) begin
            cmp("aw_id", req.aw.id, cur.id);
            cmp("aw_addr", req.aw.addr, cur.addr);
            cmp("aw_len", req.aw.len, cur.len);
            cmp("aw_size_burst", {req.aw.size, req.aw.burst}, {cur.size, cur.burst});
            cmp("aw_fixed", {req.aw.lock, req.aw.cache, req.aw.prot, req.aw.qos,
                             req.aw.region, req.aw.atop, req.aw.user}, 64'd0);
        end
        if (e_ar) begin
            cmp("ar_id", req.ar.id, cur.id);
            cmp("ar_addr", req.ar.addr, cur.addr);
            cmp("ar_len", req.ar.len, cur.len);
            cmp("ar_size_burst", {req.ar.size, req.ar.burst}, {cur.size, cur.burst});
            cmp("ar_fixed", {req.ar.lock, req.ar.cache, req.ar.prot, req.ar.qos,
                             req.ar.region, req.ar.user}, 64'd0);
        end
        if (e_w) begin
            cmp("w_data", req.w.data, cur.data + 64'(beat));
            cmp("w_strb", req.w.strb, 8'hff);
            cmp("w_last", req.w.last, beat == int'(cur.len));
        end
    endtask

    task automatic update();
        bit cmd_hs, aw_hs, ar_hs, w_hs, b_hs, r_hs, r_last;
        if (!rst_n) begin
            act = 0; a_done = 0; wr_out = 0; rd_out = 0;
            m_wr_done = 0; m_rd_done = 0; m_err = 0; alive = 0;
            return;
        end
        cmd_hs = cmd_valid && cmd_ready;
        aw_hs  = req.aw_valid && resp.aw_ready;
        ar_hs  = req.ar_valid && resp.ar_ready;
        w_hs   = req.w_valid && resp.w_ready;
        b_hs   = resp.b_valid && req.b_ready;
        r_hs   = resp.r_valid && req.r_ready;
        r_last = r_hs && resp.r.last;
        if (act && first_a < 0 && (req.aw_valid || req.ar_valid)) first_a = cyc;
        if (aw_hs) a_done = 1;
        if (ar_hs) begin
            act = 0;
            for (int k = 0; k <= int'(cur.len); k++)
                r_q.push_back('{cur.id, (rand_resp && $urandom_range(7) == 0) ? 2'b10 : 2'b00, k == int'(cur.len)});
        end
        if (w_hs) begin
            w_log.push_back(req.w.data);
            last_log.push_back(req.w.last);
            if (beat == int'(cur.len)) begin
                act = 0;
                if (force_bresp != 2'b00) b_q.push_back(force_bresp);
                else b_q.push_back((rand_resp && $urandom_range(7) == 0) ? 2'b10 : 2'b00);
            end
            beat++;
        end
        if (b_hs) begin
            m_wr_done++;
            if (resp.b.resp != 2'b00) m_err = ERR_EN;
            if (b_q.size() > 0) void'(b_q.pop_front());
            clr_b = 1;
        end
        if (r_hs) begin
            if (r_last) m_rd_done++;
            if (resp.r.resp != 2'b00) m_err = ERR_EN;
            if (r_last && first_rlast < 0) first_rlast = cyc;
            if (r_q.size() > 0) void'(r_q.pop_front());
            clr_r = 1;
        end
        if (aw_hs && !b_hs) wr_out++;
        else if (b_hs && !aw_hs && wr_out > 0) wr_out--;
        if (ar_hs && !r_last) rd_out++;
        else if (r_last && !ar_hs && rd_out > 0) rd_out--;
        if (cmd_hs) begin
            cur = cmd_q.pop_front();
            act = 1; a_done = 0; beat = 0;
            earliest = cyc + 1 + cur.delay;
            hs_cyc = cyc; first_a = -1;
            clr_cmd = 1;
            gap = (gap_max > 0) ? $urandom_range(gap_max) : 0;
        end
        alive = 1;
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        #1;
        check();
        update();
        cyc++;
    endtask

    function automatic bit idle_now();
        return !act && cmd_q.size() == 0 && !cmd_valid && b_q.size() == 0 && r_q.size() == 0
            && !resp.b_valid && !resp.r_valid && wr_out == 0 && rd_out == 0;
    endfunction

    task automatic run_idle(input int max_cyc);
        int n = 0;
        do begin
            step();
            n++;
        end while (!idle_now() && n < max_cyc);
        cmp("drain", idle_now(), 1'b1);
        step();
    endtask

    function automatic desc_t mk(input bit wr, input bit [3:0] id, input bit [31:0] addr,
                                 input bit [7:0] len, input bit [63:0] data, input int delay);
        desc_t d;
        d.wr = wr; d.id = id; d.addr = addr; d.len = len; d.size = 3'd3;
        d.burst = 2'b01; d.data = data; d.delay = delay;
        return d;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        rst_n = 1'b0; cmd_valid = 1'b0; resp = '0;
        cmd_write = 0; cmd_id = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0;
        cmd_burst = 0; cmd_data = 0; cmd_delay = 0;

        repeat (3) step();
        cmp("rst_cmd_ready", cmd_ready, 1'b0);
        cmp("rst_busy", busy, 1'b0);
        rst_req = 1'b1;
        step();
        step();
        cmp("ready_after_rst", cmd_ready, 1'b1);

        cmd_q.push_back(mk(0, 4'd3, 32'h1000, 8'd0, 64'd0, 0));
        run_idle(100);
        cmp("rd_issue_lat", first_a - hs_cyc, 1);
        cmp("rd_done_1", rd_done, 32'd1);
        cmp("rd_busy_0", busy, 1'b0);

        w_log.delete(); last_log.delete();
        cmd_q.push_back(mk(1, 4'd5, 32'h2000, 8'd3, 64'h10, 5));
        run_idle(100);
        cmp("wr_issue_lat", first_a - hs_cyc, 6);
        cmp("w_beats", w_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            cmp("w_log_data", (k < w_log.size()) ? w_log[k] : 64'hdead, 64'h10 + 64'(k));
            cmp("w_log_last", (k < last_log.size()) ? last_log[k] : 1'bx, k == 3);
        end
        cmp("wr_done_1", wr_done, 32'd1);

        r_hold = 1'b1;
        for (int k = 1; k <= 3; k++) cmd_q.push_back(mk(0, 4'(k), 32'h4000 + 32'(k * 64), 8'd0, 64'd0, 0));
        repeat (20) step();
        cmp("full_ar_valid", req.ar_valid, 1'b0);
        cmp("full_rd_done", rd_done, 32'd1);
        cmp("full_busy", busy, 1'b1);
        first_rlast = -1;
        r_hold = 1'b0;
        run_idle(100);
        cmp("full_release_lat", first_a - first_rlast, 1);
        cmp("full_rd_done_4", rd_done, 32'd4);

        p_aw = 0;
        cnt = 0;
        cmd_q.push_back(mk(1, 4'd7, 32'h3000, 8'd1, 64'hab, 0));
        repeat (11) begin
            step();
            if (req.aw_valid && req.aw.addr == 32'h3000 && !req.w_valid) cnt++;
        end
        cmp("aw_stall_cycles", cnt, 10);
        p_aw = 100;
        run_idle(100);

        force_bresp = 2'b10;
        cmd_q.push_back(mk(1, 4'd1, 32'h5000, 8'd0, 64'h1, 0));
        run_idle(100);
        force_bresp = 2'b00;
        cmp("err_set", err, ERR_EN);
        cmd_q.push_back(mk(1, 4'd2, 32'h5100, 8'd0, 64'h2, 0));
        run_idle(100);
        cmp("err_sticky", err, ERR_EN);

        cmd_q.push_back(mk(1, 4'd4, 32'h6000, 8'd3, 64'h55, 0));
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!(act && a_done && beat == 1) && cnt < 50);
        cmp("reach_beat2", beat, 1);
        rst_req = 1'b0;
        step();
        cmp("rst_mid_valids", {req.aw_valid, req.w_valid, req.ar_valid}, 3'b000);
        cmp("rst_mid_wr_done", wr_done, 32'd0);
        cmp("rst_mid_busy", busy, 1'b0);
        rst_req = 1'b1;
        step();
        step();
        cmp("rst_mid_ready", cmd_ready, 1'b1);
        b_q.push_back(2'b00);
        run_idle(20);
        cmp("stray_b_wr_done", wr_done, 32'd1);
        cmp("stray_b_busy", busy, 1'b0);

        p_aw = 70; p_w = 70; p_ar = 70; p_b = 60; p_r = 60;
        gap_max = 3; rand_resp = 1'b1;
        for (int k = 0; k < 60; k++) begin
            desc_t d;
            d = mk($urandom_range(1), 4'($urandom), {$urandom} & 32'hffff_fff8,
                   8'($urandom_range(4)), {$urandom, $urandom}, $urandom_range(4));
            d.burst = 2'($urandom_range(2));
            d.size  = 3'($urandom_range(3));
            cmd_q.push_back(d);
        end
        run_idle(5000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
